alu_seq: RTL

Parametrised, handshaked successor to the processor's 32-bit combinational ALU, for the multi-cycle datapath. It keeps the legacy 3-bit operation encoding as a subset of a 4-bit opcode, and adds arithmetic shift, signed/unsigned compare, status flags and an optional iterative multiplier. It registers its result and exchanges operands and results over valid/ready handshakes, so the control unit can stall on multi-cycle operations.

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/alu_mul_iter.sv | 47 ++++
 rtl/alu_seq.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM state and illegal-op predicate for alu_seq.
// Optional feature macro: ALU_SEQ_MUL_EN (op 11 is legal only when defined).
package alu_seq_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic op_illegal(
    input logic [3:0] op
  );
`ifdef ALU_SEQ_MUL_EN
    return op > OP_MUL;
`else
    return op > OP_SLTU;
`endif
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one partial product per cycle.
// done is raised during the last iteration; product is valid in that cycle.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_n;
  logic [CW-1:0]    cnt;

  assign acc_n   = acc + (mplier[0] ? mcand : '0);
  assign done    = cnt == CW'(1);
  assign product = acc_n;

  // Load operands on start, then add one shifted partial product per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
    end else if (cnt != '0) begin
      acc    <= acc_n;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU with flags and optional iterative MUL.
// Define ALU_SEQ_MUL_EN to enable op 11 (MUL) and the CALC state.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_t state;
  state_t state_d;

  logic             accept;
  logic             load;
  logic             is_mul;
  logic [SW-1:0]    sh;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_v;
  logic             alu_e;

  assign in_ready  = (state == S_IDLE)
                  || (state == S_DONE && out_ready);
  assign out_valid = state == S_DONE;
  assign accept    = in_valid && in_ready;
  assign load      = accept && !is_mul;
  assign sh        = b[SW-1:0];
  assign sum       = {1'b0, a} + {1'b0, b};
  assign dif       = {1'b0, a} - {1'b0, b};

`ifdef ALU_SEQ_MUL_EN
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_p;

  assign is_mul    = op == OP_MUL;
  assign mul_start = accept && is_mul;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_p)
  );
`else
  assign is_mul = 1'b0;
`endif

  // Single-cycle datapath evaluated on the live operands at acceptance.
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    alu_e = op_illegal(op);
    case (op)
      OP_AND:  alu_r = a & b;
      OP_OR:   alu_r = a | b;
      OP_XOR:  alu_r = a ^ b;
      OP_NOR:  alu_r = ~(a | b);
      OP_ADD: begin
        alu_r = sum[MSB:0];
        alu_c = sum[WIDTH];
        alu_v = (a[MSB] == b[MSB])
             && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_r = dif[MSB:0];
        alu_c = dif[WIDTH];
        alu_v = (a[MSB] != b[MSB])
             && (dif[MSB] != a[MSB]);
      end
      OP_SRL:  alu_r = a >> sh;
      OP_SLL:  alu_r = a << sh;
      OP_SRA:  alu_r = $unsigned($signed(a) >>> sh);
      OP_SLT:  alu_r = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: alu_r = WIDTH'(a < b);
      default: alu_r = '0;
    endcase
  end

  // Next-state logic; DONE chains straight into a new op on handshake.
  always_comb begin
    state_d = state;
    unique case (1'b1)
      state == S_IDLE: begin
        if (accept) state_d = is_mul ? S_CALC : S_DONE;
      end
      state == S_DONE: begin
        if (accept) state_d = is_mul ? S_CALC : S_DONE;
        else if (out_ready) state_d = S_IDLE;
      end
`ifdef ALU_SEQ_MUL_EN
      state == S_CALC: begin
        if (mul_done) state_d = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Output registers; untouched while waiting, so DONE holds stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
    end else if (load) begin
      result   <= alu_r;
      zero     <= alu_r == '0;
      carry    <= alu_c;
      overflow <= alu_v;
      err      <= alu_e;
`ifdef ALU_SEQ_MUL_EN
    end else if (state == S_CALC && mul_done) begin
      result   <= mul_p;
      zero     <= mul_p == '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
`endif
    end
  end

endmodule
